qubit2_measure: RTL
===================

# qubit2_measure

Two-qubit projective measurement unit: consumes a 4-amplitude complex state vector (same signed Q2.14 amplitude format produced by the gate modules, e.g. after CNOT) over a valid/ready handshake. It computes per-basis probabilities with one shared multiplier, then draws a random threshold. It returns the measured basis index, that outcome's probability and the projected (unnormalized) state vector. It is the consumer/readout end of the gate datapath.

## Interface
- LFSR_SEED, 16'hACE1, internal LFSR reset value (unused when QMEAS_EXT_RAND_EN is defined)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  state vector present
- in_ready  out  1  high only in IDLE
- c00_in_re/c00_in_im … c11_in_re/c11_in_im  in  16 each (signed)  amplitudes |00>,|01>,|10>,|11>, Q2.14 (1.0 = 16384)
- rand_in  in  16  external random word (exists only with QMEAS_EXT_RAND_EN)
- out_valid  out  1  result present
- out_ready  in  1  result consumed
- outcome  out  2  measured basis index (0=|00> … 3=|11>)
- prob  out  20  unsigned probability of outcome, 1.0 = 65536
- zero_err  out  1  total probability was zero
- c00_out_re … c11_out_im  out  16 each (signed)  projected state: selected amplitude passed unchanged, other three zeroed

## Operation
- p_k = (re_k² + im_k²) >> 12, truncating, 20-bit unsigned.
- total = Σp_k, 22 bits.
- cum_k = running sum of p_k.
- t = (r × total) >> 16, where r is the 16-bit random word.
- FSM states:
  - IDLE → SQ on in_valid && in_ready. Capture all amplitudes; capture rand_in or advance the LFSR.
  - SQ: 8 cycles, one square per cycle (re0, im0, re1, … im3), accumulating p_k and cum_k.
  - THR: 1 cycle. Compute t on the same multiplier.
  - SEL: 1 cycle. outcome = lowest k with cum_k > t; drive prob, projected state and out_valid.
  - OUT: hold every output stable until out_ready. Then go to IDLE and clear out_valid.
- total == 0: zero_err=1, outcome=0, prob=0, all output amplitudes 0, result still delivered via out_valid.
- Unnormalized input is legal. Selection is relative to total, so the result is still correctly weighted.
- r < 2^16 guarantees t < total, so an outcome always exists when total > 0.
- Most negative amplitude (-32768) is legal: p_k up to 2^19, with no overflow at the stated widths.

## Timing
- Reset values:
  - outputs: out_valid=0, outcome=0, prob=0, zero_err=0, all output amplitudes 0.
  - status and internal state: in_ready=1, FSM=IDLE, LFSR=LFSR_SEED.
- Latency: capture on edge E0; out_valid rises after edge E10 (10 cycles).
- Throughput: one measurement per ≥11 cycles, no overlap. in_ready stays low from the cycle after capture until the cycle after the out handshake.
- in_valid while busy is ignored (not queued).
- out_ready held high: out_valid lasts exactly 1 cycle and in_ready returns the next cycle.
- out_ready low: outputs frozen indefinitely.
- rst_n asserted mid-measurement: immediate abort to reset values; the partial result is discarded.

## Configuration
- QMEAS_EXT_RAND_EN defined:
  - rand_in port exists and is sampled at the capture edge.
  - No LFSR is instantiated. Results are fully deterministic from inputs.
- QMEAS_EXT_RAND_EN undefined:
  - No rand_in port.
  - Internal 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, seeded LFSR_SEED.
  - The LFSR advances exactly once per accepted input; r is the post-advance value.

## Structure
- Package qmeas_pkg holds:
  - AMP_W=16, AMP_FRAC=14, PROB_SHIFT=12, PROB_W=20, SUM_W=22
  - FSM state enum (IDLE, SQ, THR, SEL, OUT)
  - LFSR tap mask
- Sub-module qmeas_lfsr: 16-bit LFSR with seed parameter and advance enable, instantiated only without QMEAS_EXT_RAND_EN.
- Single shared multiplier in the top level, muxed between squaring and threshold scaling.

## Test plan
- **Basis state.** Drive |00> = (16384,0,0,0,0,0,0,0), any r → outcome=0, prob=65536, c00_out_re=16384, all else 0, out_valid 10 cycles after capture.
- **Bell state, low r.** Drive (11585,0,0,0,0,0,11585,0) with rand_in=0x0000 → p=32766, total=65532, outcome=0, prob=32766, c11_out 0.
- **Bell state, high r.** Same vector with rand_in=0xFFFF → t=65531, outcome=3, prob=32766, c11_out_re=11585, c00_out 0.
- **Zero vector.** All zero amplitudes → zero_err=1, outcome=0, prob=0, out_valid asserted.
- **Backpressure and ignored input.**
  - Hold out_ready=0 for 20 cycles with in_valid held high → outputs stable, in_ready=0, second vector not taken.
  - Release → in_ready=1 next cycle, second vector captured.
- **Mid-operation reset.** Assert rst_n=0 during SQ → all outputs at reset values immediately. A fresh measurement after release completes normally.

Source files
------------

// File: rtl/qmeas_pkg.sv
// rtl/qmeas_pkg.sv - shared widths, FSM encoding and LFSR taps for the two-qubit measurement unit
package qmeas_pkg;

    localparam int AMP_W      = 16;
    localparam int AMP_FRAC   = 14;
    localparam int PROB_SHIFT = 12;
    localparam int PROB_W     = 20;
    localparam int SUM_W      = 22;

    // Random word is a fraction on the probability scale (1.0 = 2^16).
    localparam int RAND_W     = 2 * AMP_FRAC - PROB_SHIFT;
    localparam int SQ_W       = 2 * AMP_W;
    localparam int MUL_A_W    = SUM_W + 1;
    localparam int MUL_B_W    = RAND_W + 1;
    localparam int MUL_P_W    = MUL_A_W + MUL_B_W;

    // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB.
    localparam logic [RAND_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        IDLE,
        SQ,
        THR,
        SEL,
        OUT
    } state_e;

    typedef logic signed [AMP_W-1:0] amp_t;

    function automatic logic lfsr_feedback(input logic [RAND_W-1:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/qubit2_measure_if.sv
// rtl/qubit2_measure_if.sv - state-vector input and measurement-result handshake bundle
// rand_in exists only when QMEAS_EXT_RAND_EN is defined.
interface qubit2_measure_if;
    import qmeas_pkg::*;

    logic in_valid;
    logic in_ready;
    amp_t c00_in_re, c00_in_im, c01_in_re, c01_in_im;
    amp_t c10_in_re, c10_in_im, c11_in_re, c11_in_im;
`ifdef QMEAS_EXT_RAND_EN
    logic [RAND_W-1:0] rand_in;
`endif

    logic              out_valid;
    logic              out_ready;
    logic [1:0]        outcome;
    logic [PROB_W-1:0] prob;
    logic              zero_err;
    amp_t c00_out_re, c00_out_im, c01_out_re, c01_out_im;
    amp_t c10_out_re, c10_out_im, c11_out_re, c11_out_im;

    modport master (
`ifdef QMEAS_EXT_RAND_EN
        output rand_in,
`endif
        output in_valid, c00_in_re, c00_in_im, c01_in_re, c01_in_im,
        output c10_in_re, c10_in_im, c11_in_re, c11_in_im, out_ready,
        input  in_ready, out_valid, outcome, prob, zero_err,
        input  c00_out_re, c00_out_im, c01_out_re, c01_out_im,
        input  c10_out_re, c10_out_im, c11_out_re, c11_out_im
    );

    modport slave (
`ifdef QMEAS_EXT_RAND_EN
        input  rand_in,
`endif
        input  in_valid, c00_in_re, c00_in_im, c01_in_re, c01_in_im,
        input  c10_in_re, c10_in_im, c11_in_re, c11_in_im, out_ready,
        output in_ready, out_valid, outcome, prob, zero_err,
        output c00_out_re, c00_out_im, c01_out_re, c01_out_im,
        output c10_out_re, c10_out_im, c11_out_re, c11_out_im
    );

endinterface

// File: rtl/qmeas_lfsr.sv
// rtl/qmeas_lfsr.sv - 16-bit Fibonacci LFSR that steps once per advance pulse
module qmeas_lfsr
    import qmeas_pkg::*;
#(
    parameter logic [RAND_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv_i,
    output logic [RAND_W-1:0] state_o
);

    logic [RAND_W-1:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else if (adv_i) begin
            lfsr_q <= {lfsr_q[RAND_W-2:0], lfsr_feedback(lfsr_q)};
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/qubit2_measure.sv
// rtl/qubit2_measure.sv - two-qubit projective measurement: probabilities, random threshold, projection
// QMEAS_EXT_RAND_EN selects the external rand_in word instead of the internal LFSR.
module qubit2_measure
    import qmeas_pkg::*;
#(
    parameter logic [RAND_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    qubit2_measure_if.slave  io
);

    state_e            state_q;
    logic [2:0]        idx_q;
    amp_t              amp_q     [8];
    logic [SQ_W-1:0]   sq_acc_q;
    logic [PROB_W-1:0] p_q       [4];
    logic [SUM_W-1:0]  cum_q     [4];
    logic [SUM_W-1:0]  thr_q;

    logic              out_valid_q;
    logic [1:0]        outcome_q;
    logic [PROB_W-1:0] prob_q;
    logic              zero_err_q;
    amp_t              out_amp_q [8];

    logic [RAND_W-1:0] r_w;
    logic              capture;

    assign capture = (state_q == IDLE) && io.in_valid;

`ifdef QMEAS_EXT_RAND_EN
    logic [RAND_W-1:0] rand_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rand_q <= '0;
        end else if (capture) begin
            rand_q <= io.rand_in;
        end
    end

    assign r_w = rand_q;
`else
    // The LFSR holds still while busy, so its state is the post-advance r at THR.
    qmeas_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv_i   (capture),
        .state_o (r_w)
    );
`endif

    // One multiplier: signed amplitude squares in SQ, unsigned r * total in THR.
    logic signed [MUL_A_W-1:0] mul_a;
    logic signed [MUL_B_W-1:0] mul_b;
    logic signed [MUL_P_W-1:0] mul_p;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state_q == THR) begin
            mul_a = {1'b0, cum_q[3]};
            mul_b = {1'b0, r_w};
        end else begin
            mul_a = MUL_A_W'(amp_q[idx_q]);
            mul_b = MUL_B_W'(amp_q[idx_q]);
        end
    end

    assign mul_p = mul_a * mul_b;

    logic [SQ_W-1:0]   sq_w;
    logic [SQ_W-1:0]   pair_sum_d;
    logic [PROB_W-1:0] p_d;
    logic [SUM_W-1:0]  run_d;
    logic [SUM_W-1:0]  cum_d;
    logic [SUM_W-1:0]  thr_d;

    // re^2 + im^2 is summed at full width before the truncating shift.
    assign sq_w       = SQ_W'(mul_p);
    assign pair_sum_d = sq_acc_q + sq_w;
    assign p_d        = PROB_W'(pair_sum_d >> PROB_SHIFT);
    assign run_d      = (idx_q[2:1] == 2'd0) ? '0 : cum_q[idx_q[2:1] - 2'd1];
    assign cum_d      = run_d + SUM_W'(p_d);
    assign thr_d      = SUM_W'(mul_p >> RAND_W);

    logic [1:0] sel_d;
    logic       zero_d;

    // Descending scan so the lowest basis index with cum_k > t wins.
    always_comb begin
        sel_d  = 2'd0;
        zero_d = (cum_q[3] == '0);
        for (int k = 3; k >= 0; k--) begin
            if (cum_q[k] > thr_q) begin
                sel_d = 2'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            sq_acc_q    <= '0;
            thr_q       <= '0;
            out_valid_q <= 1'b0;
            outcome_q   <= '0;
            prob_q      <= '0;
            zero_err_q  <= 1'b0;
            for (int j = 0; j < 8; j++) begin
                amp_q[j]     <= '0;
                out_amp_q[j] <= '0;
            end
            for (int k = 0; k < 4; k++) begin
                p_q[k]   <= '0;
                cum_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (io.in_valid) begin
                        amp_q[0] <= io.c00_in_re;
                        amp_q[1] <= io.c00_in_im;
                        amp_q[2] <= io.c01_in_re;
                        amp_q[3] <= io.c01_in_im;
                        amp_q[4] <= io.c10_in_re;
                        amp_q[5] <= io.c10_in_im;
                        amp_q[6] <= io.c11_in_re;
                        amp_q[7] <= io.c11_in_im;
                        idx_q    <= '0;
                        state_q  <= SQ;
                    end
                end
                SQ: begin
                    if (!idx_q[0]) begin
                        sq_acc_q <= sq_w;
                    end else begin
                        p_q[idx_q[2:1]]   <= p_d;
                        cum_q[idx_q[2:1]] <= cum_d;
                    end
                    idx_q <= idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_q <= THR;
                    end
                end
                THR: begin
                    thr_q   <= thr_d;
                    state_q <= SEL;
                end
                SEL: begin
                    zero_err_q  <= zero_d;
                    outcome_q   <= zero_d ? 2'd0 : sel_d;
                    prob_q      <= zero_d ? '0 : p_q[sel_d];
                    for (int j = 0; j < 8; j++) begin
                        out_amp_q[j] <= (!zero_d && (2'(j >> 1) == sel_d)) ? amp_q[j] : '0;
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (io.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io.in_ready   = (state_q == IDLE);
    assign io.out_valid  = out_valid_q;
    assign io.outcome    = outcome_q;
    assign io.prob       = prob_q;
    assign io.zero_err   = zero_err_q;
    assign io.c00_out_re = out_amp_q[0];
    assign io.c00_out_im = out_amp_q[1];
    assign io.c01_out_re = out_amp_q[2];
    assign io.c01_out_im = out_amp_q[3];
    assign io.c10_out_re = out_amp_q[4];
    assign io.c10_out_im = out_amp_q[5];
    assign io.c11_out_re = out_amp_q[6];
    assign io.c11_out_im = out_amp_q[7];

endmodule
